// File: rtl/exp6_exibe_sequencia_pkg.sv
// rtl/exp6_exibe_sequencia_pkg.sv - state encodings and default sizes for the sequence replayer
package exp6_pkg;

  localparam int ADDR_W_DEF    = 4;
  localparam int DATA_W_DEF    = 4;
  localparam int T_ACESO_DEF   = 1000;
  localparam int T_APAGADO_DEF = 500;

  // Encodings double as db_estado for the hexa7seg display
  typedef enum logic [3:0] {
    INICIAL = 4'h0,
    LE      = 4'h1,
    ACESO   = 4'h2,
    APAGADO = 4'h3,
    FIM     = 4'hF
  } estado_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/exp6_exibe_sequencia_if.sv
// rtl/exp6_exibe_sequencia_if.sv - memory read port shared with the fluxo de dados
interface exp6_exibe_sequencia_if
  import exp6_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] dado;

  modport master (output endereco, input dado);
  modport slave  (input endereco, output dado);

endinterface

// File: rtl/exp6_exibe_sequencia_contador_tempo.sv
// rtl/exp6_exibe_sequencia_contador_tempo.sv - mod-M timer, fim flags the last cycle of a programmable period
module contador_tempo
  import exp6_pkg::*;
#(
  parameter int M = T_ACESO_DEF,
  parameter int W = $clog2(M + 1)
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_zera,
  input  logic         i_conta,
  input  logic [W-1:0] i_limite,
  output logic         o_fim
);

  logic [W-1:0] r_valor;

  // Wraps at M-1 instead of saturating
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_valor <= '0;
    end else if (i_zera) begin
      r_valor <= '0;
    end else if (i_conta) begin
      r_valor <= (r_valor == W'(M - 1)) ? '0 : r_valor + 1'b1;
    end
  end

  assign o_fim = (r_valor == i_limite - 1'b1);

endmodule

// File: rtl/exp6_exibe_sequencia.sv
// rtl/exp6_exibe_sequencia.sv - replays stored sequence on leds, addresses 0..rodada
// Optional fast level via EXIBE_NIVEL_TEMPO_EN (adds nivel_tempo input).
module exp6_exibe_sequencia
  import exp6_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int T_ACESO   = T_ACESO_DEF,
  parameter int T_APAGADO = T_APAGADO_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic [ADDR_W-1:0]      rodada,
`ifdef EXIBE_NIVEL_TEMPO_EN
  input  logic                   nivel_tempo,
`endif
  exp6_exibe_sequencia_if.master mem,
  output logic [DATA_W-1:0]      leds,
  output logic                   exibindo,
  output logic                   pronto,
  output logic [3:0]             db_estado
);

  localparam int T_MAX = max_int(T_ACESO, T_APAGADO);
  localparam int TW    = $clog2(T_MAX + 1);

  estado_t           r_estado;
  estado_t           w_estado_prox;
  logic [ADDR_W-1:0] r_endereco;
  logic [ADDR_W-1:0] r_rodada;
  logic [DATA_W-1:0] r_leds;
  logic              w_zera;
  logic              w_conta;
  logic              w_fim;
  logic [TW-1:0]     w_limite;
  logic [TW-1:0]     w_lim_aceso;
  logic [TW-1:0]     w_lim_apagado;
  logic              w_ultimo;

`ifdef EXIBE_NIVEL_TEMPO_EN
  logic r_nivel;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_nivel <= 1'b0;
    end else if (r_estado == INICIAL && iniciar) begin
      r_nivel <= nivel_tempo;
    end
  end

  assign w_lim_aceso   = r_nivel ? TW'(T_ACESO / 2)   : TW'(T_ACESO);
  assign w_lim_apagado = r_nivel ? TW'(T_APAGADO / 2) : TW'(T_APAGADO);
`else
  assign w_lim_aceso   = TW'(T_ACESO);
  assign w_lim_apagado = TW'(T_APAGADO);
`endif

  assign w_ultimo = (r_endereco == r_rodada);

  contador_tempo #(
    .M (T_MAX),
    .W (TW)
  ) u_contador_tempo (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_zera   (w_zera),
    .i_conta  (w_conta),
    .i_limite (w_limite),
    .o_fim    (w_fim)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= INICIAL;
    end else begin
      r_estado <= w_estado_prox;
    end
  end

  // Timer is cleared on every state change, so each state counts from 0
  always_comb begin
    w_estado_prox = r_estado;
    w_zera        = 1'b1;
    w_conta       = 1'b0;
    w_limite      = w_lim_aceso;
    case (r_estado)
      INICIAL: begin
        if (iniciar) w_estado_prox = LE;
      end
      LE: begin
        w_estado_prox = ACESO;
      end
      ACESO: begin
        w_limite = w_lim_aceso;
        if (w_fim) begin
          w_estado_prox = APAGADO;
        end else begin
          w_zera  = 1'b0;
          w_conta = 1'b1;
        end
      end
      APAGADO: begin
        w_limite = w_lim_apagado;
        if (w_fim) begin
          w_estado_prox = w_ultimo ? FIM : LE;
        end else begin
          w_zera  = 1'b0;
          w_conta = 1'b1;
        end
      end
      FIM: begin
        w_estado_prox = INICIAL;
      end
      default: begin
        w_estado_prox = INICIAL;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_endereco <= '0;
      r_rodada   <= '0;
      r_leds     <= '0;
    end else begin
      case (r_estado)
        INICIAL: begin
          if (iniciar) begin
            r_rodada   <= rodada;
            r_endereco <= '0;
          end
        end
        LE: begin
          r_leds <= mem.dado;
        end
        ACESO: begin
          if (w_fim) r_leds <= '0;
        end
        APAGADO: begin
          if (w_fim && !w_ultimo) r_endereco <= r_endereco + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign mem.endereco = r_endereco;
  assign leds         = r_leds;
  assign exibindo     = (r_estado != INICIAL);
  assign pronto       = (r_estado == FIM);
  assign db_estado    = r_estado;

endmodule

// File: tb/tb_exp6_exibe_sequencia.sv
// tb/tb_exp6_exibe_sequencia.sv - directed bench for the sequence replayer, T_ACESO=4, T_APAGADO=2
module tb_exp6_exibe_sequencia;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic [3:0] rodada;
  logic       nivel_tempo;
  logic [3:0] leds;
  logic       exibindo;
  logic       pronto;
  logic [3:0] db_estado;

  int total;
  int bad;

  exp6_exibe_sequencia_if #(.ADDR_W(4), .DATA_W(4)) mif ();

  // Memory holds 1,2,4,8 repeating; endereco is registered so reads take one cycle
  assign mif.dado = 4'(1 << mif.endereco[1:0]);

  exp6_exibe_sequencia #(
    .ADDR_W    (4),
    .DATA_W    (4),
    .T_ACESO   (4),
    .T_APAGADO (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .rodada    (rodada),
`ifdef EXIBE_NIVEL_TEMPO_EN
    .nivel_tempo (nivel_tempo),
`endif
    .mem       (mif),
    .leds      (leds),
    .exibindo  (exibindo),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp_v);
    end
  endtask

  // Checks one replay cycle by cycle, starting in the LE cycle (t=1); changes rodada at t=3
  task automatic replay(input int r, input int r_mid);
    int         last;
    int         e;
    int         p;
    logic [3:0] exp_st;
    logic [3:0] exp_end;
    logic [3:0] exp_leds;
    last = 7 * (r + 1) + 1;
    for (int t = 1; t <= last + 1; t++) begin
      if (t == last + 1) begin
        exp_st = 4'h0; exp_end = 4'(r); exp_leds = 4'h0;
      end else if (t == last) begin
        exp_st = 4'hF; exp_end = 4'(r); exp_leds = 4'h0;
      end else begin
        e = (t - 1) / 7;
        p = (t - 1) % 7;
        exp_end  = 4'(e);
        exp_st   = (p == 0) ? 4'h1 : (p <= 4) ? 4'h2 : 4'h3;
        exp_leds = (p >= 1 && p <= 4) ? 4'(1 << (e % 4)) : 4'h0;
      end
      check("estado",   t, 32'(db_estado),    32'(exp_st));
      check("leds",     t, 32'(leds),         32'(exp_leds));
      check("endereco", t, 32'(mif.endereco), 32'(exp_end));
      check("pronto",   t, 32'(pronto),       32'(t == last));
      check("exibindo", t, 32'(exibindo),     32'(exp_st != 4'h0));
      if (t == 3) rodada = 4'(r_mid);
      step();
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset       = 1'b0;
    iniciar     = 1'b0;
    rodada      = 4'd0;
    nivel_tempo = 1'b0;
    step();
    step();
    check("rst_estado",   0, 32'(db_estado),    32'h0);
    check("rst_leds",     0, 32'(leds),         32'h0);
    check("rst_endereco", 0, 32'(mif.endereco), 32'h0);
    check("rst_exibindo", 0, 32'(exibindo),     32'h0);
    check("rst_pronto",   0, 32'(pronto),       32'h0);
    reset = 1'b1;
    step();
    step();
    check("idle_estado", 0, 32'(db_estado), 32'h0);

    // 1: rodada=2
    rodada = 4'd2; iniciar = 1'b1; step(); iniciar = 1'b0;
    replay(2, 2);

    // 2: rodada=0, single entry
    rodada = 4'd0; iniciar = 1'b1; step(); iniciar = 1'b0;
    replay(0, 0);

    // 3: rodada=15, all entries, no wrap
    rodada = 4'd15; iniciar = 1'b1; step(); iniciar = 1'b0;
    replay(15, 15);

    // 4: iniciar held, rodada changed mid-run; restart right after FIM
    rodada = 4'd1; iniciar = 1'b1; step();
    replay(1, 3);
    iniciar = 1'b0;
    replay(3, 3);

    // 5: async reset during ACESO of entry 1
    rodada = 4'd2; iniciar = 1'b1; step(); iniciar = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("pre_rst_estado", 9, 32'(db_estado), 32'h2);
    check("pre_rst_leds",   9, 32'(leds),      32'h2);
    reset = 1'b0;
    #1;
    check("mid_rst_leds",     9, 32'(leds),         32'h0);
    check("mid_rst_endereco", 9, 32'(mif.endereco), 32'h0);
    check("mid_rst_exibindo", 9, 32'(exibindo),     32'h0);
    check("mid_rst_estado",   9, 32'(db_estado),    32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_rst_pronto", 10 + i, 32'(pronto), 32'h0);
    end
    reset = 1'b1;
    step();
    check("post_rst_idle", 0, 32'(db_estado), 32'h0);
    rodada = 4'd1; iniciar = 1'b1; step(); iniciar = 1'b0;
    replay(1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
